// File: rtl/pe_bus_fabric_if.sv
// Core-side request bus, decoded target bus, putchar stream and error reporting of the PE fabric.
// Signals with a _c suffix are combinational outputs of the fabric.
interface pe_bus_fabric_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned N_TARGETS  = 3
);
   localparam int unsigned NB = DATA_WIDTH / 8;

   logic                            cpu_req;
   logic [ADDR_WIDTH-1:0]           cpu_addr;
   logic [NB-1:0]                   cpu_wb;
   logic [DATA_WIDTH-1:0]           cpu_wdata;
   logic [DATA_WIDTH-1:0]           cpu_rdata_c;
   logic                            cpu_stall_c;
   logic [N_TARGETS-1:0]            tgt_sel_c;
   logic [ADDR_WIDTH-1:0]           tgt_addr_c;
   logic [NB-1:0]                   tgt_wb_c;
   logic [DATA_WIDTH-1:0]           tgt_wdata_c;
   logic [N_TARGETS*DATA_WIDTH-1:0] tgt_rdata;
   logic [N_TARGETS-1:0]            tgt_ready;
   logic [7:0]                      putc_data_c;
   logic                            putc_valid;
   logic                            putc_ready;
   logic                            err_irq;
   logic [ADDR_WIDTH-1:0]           err_addr;
   logic [7:0]                      err_count;
   logic                            err_clr;

   // Environment side: core, targets and host
   modport master (
      output cpu_req, cpu_addr, cpu_wb, cpu_wdata, tgt_rdata, tgt_ready, putc_ready, err_clr,
      input  cpu_rdata_c, cpu_stall_c, tgt_sel_c, tgt_addr_c, tgt_wb_c, tgt_wdata_c,
             putc_data_c, putc_valid, err_irq, err_addr, err_count
   );

   // Fabric side
   modport slave (
      input  cpu_req, cpu_addr, cpu_wb, cpu_wdata, tgt_rdata, tgt_ready, putc_ready, err_clr,
      output cpu_rdata_c, cpu_stall_c, tgt_sel_c, tgt_addr_c, tgt_wb_c, tgt_wdata_c,
             putc_data_c, putc_valid, err_irq, err_addr, err_count
   );
endinterface

// File: rtl/pe_bus_fabric.sv
// Memory-map fabric for a manycore PE: region decode, target stall, one-cycle read return,
// byte-lane swap, console putchar FIFO and sticky illegal-access reporting.
module pe_bus_fabric #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           N_TARGETS  = 3,
   parameter logic [ADDR_WIDTH-1:0] TGT_BASE [N_TARGETS] =
      '{ADDR_WIDTH'(32'h0000_0000), ADDR_WIDTH'(32'h4000_0000), ADDR_WIDTH'(32'hE100_0000)},
   parameter logic [ADDR_WIDTH-1:0] TGT_MASK [N_TARGETS] =
      '{ADDR_WIDTH'(32'h0000_0FFF), ADDR_WIDTH'(32'h0000_FFFF), ADDR_WIDTH'(32'h00FF_FFFF)},
   parameter logic [ADDR_WIDTH-1:0] PUTC_ADDR  = ADDR_WIDTH'(32'h1697),
   parameter int unsigned           PUTC_DEPTH = 8,
   parameter bit                    BYTE_SWAP  = 1'b1,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hDEAD_BEEF)
) (
   input logic            clk,
   input logic            rst,
   pe_bus_fabric_if.slave bus
);
   localparam int unsigned NB = DATA_WIDTH / 8;
   localparam int unsigned PW = $clog2(PUTC_DEPTH);
   localparam int unsigned IW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

   typedef enum logic [1:0] {RSP_NONE, RSP_TGT, RSP_PUTC, RSP_ILL} rsp_e;

   function automatic logic [DATA_WIDTH-1:0] swap(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      r = d;
      if (BYTE_SWAP) begin
         for (int i = 0; i < int'(NB); i++) r[i*8 +: 8] = d[(int'(NB)-1-i)*8 +: 8];
      end
      return r;
   endfunction

   rsp_e          kind_c, rsp_q, rsp_d;
   logic [IW-1:0] idx_c, idx_q, idx_d;
   logic          hit, accept, push, pop, full;

   logic [7:0]    mem [PUTC_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count, count_d;

   // Putchar address first, then lowest-indexed matching region
   always_comb begin
      kind_c = RSP_NONE;
      idx_c  = '0;
      hit    = 1'b0;
      if (bus.cpu_req) begin
         if (bus.cpu_addr == PUTC_ADDR) begin
            kind_c = RSP_PUTC;
         end else begin
            for (int k = int'(N_TARGETS) - 1; k >= 0; k--) begin
               if ((bus.cpu_addr & ~TGT_MASK[k]) == TGT_BASE[k]) begin
                  hit   = 1'b1;
                  idx_c = IW'(k);
               end
            end
            kind_c = hit ? RSP_TGT : RSP_ILL;
         end
      end
   end

   // A pop in the same cycle frees the slot, so a full FIFO only stalls without one
   always_comb begin
      full            = (count == (PW+1)'(PUTC_DEPTH));
      pop             = bus.putc_valid & bus.putc_ready;
      bus.cpu_stall_c = ((kind_c == RSP_TGT) && !bus.tgt_ready[idx_c]) ||
                        ((kind_c == RSP_PUTC) && (|bus.cpu_wb) && full && !pop);
      accept          = bus.cpu_req & ~bus.cpu_stall_c;
      push            = accept && (kind_c == RSP_PUTC) && (|bus.cpu_wb);
      count_d         = count + (PW+1)'(push) - (PW+1)'(pop);
   end

   always_comb begin
      bus.tgt_sel_c   = '0;
      bus.tgt_addr_c  = '0;
      bus.tgt_wb_c    = '0;
      bus.tgt_wdata_c = swap(bus.cpu_wdata);
      if (kind_c == RSP_TGT) begin
         bus.tgt_sel_c  = N_TARGETS'(1) << idx_c;
         bus.tgt_addr_c = bus.cpu_addr & TGT_MASK[idx_c];
         bus.tgt_wb_c   = bus.cpu_wb;
      end
   end

   // Response kind of the transaction accepted last cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_q <= RSP_NONE;
         idx_q <= '0;
      end else begin
         rsp_q <= rsp_d;
         idx_q <= idx_d;
      end
   end

   always_comb begin
      rsp_d = RSP_NONE;
      idx_d = '0;
      if (accept) begin
         rsp_d = kind_c;
         idx_d = idx_c;
      end
   end

   always_comb begin
      bus.cpu_rdata_c = '0;
      case (rsp_q)
         RSP_TGT:           bus.cpu_rdata_c = swap(bus.tgt_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH]);
         RSP_PUTC, RSP_ILL: bus.cpu_rdata_c = ERR_DATA;
         default:           bus.cpu_rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.cpu_wdata[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         bus.putc_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count          <= count_d;
         bus.putc_valid <= (count_d != '0);
      end
   end

   assign bus.putc_data_c = bus.putc_valid ? mem[rd_ptr] : 8'h00;

   // A new illegal access overrides a concurrent clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.err_irq   <= 1'b0;
         bus.err_addr  <= '0;
         bus.err_count <= '0;
      end else if (accept && (kind_c == RSP_ILL)) begin
         bus.err_irq <= 1'b1;
         if (!bus.err_irq || bus.err_clr) bus.err_addr <= bus.cpu_addr;
         if (bus.err_clr)                   bus.err_count <= 8'd1;
         else if (bus.err_count != 8'hFF)   bus.err_count <= bus.err_count + 8'd1;
      end else if (bus.err_clr) begin
         bus.err_irq   <= 1'b0;
         bus.err_addr  <= '0;
         bus.err_count <= '0;
      end
   end
endmodule

// File: tb/tb_pe_bus_fabric.sv
// Randomized and directed checking of pe_bus_fabric against a transaction-level model
// built from the memory map, a character queue and error counters.
module tb_pe_bus_fabric;
   localparam logic [31:0] BASE [3] = '{32'h0000_0000, 32'h4000_0000, 32'hE100_0000};
   localparam logic [31:0] MASK [3] = '{32'h0000_0FFF, 32'h0000_FFFF, 32'h00FF_FFFF};
   localparam logic [31:0] PUTC = 32'h1697;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
   localparam int          DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pe_bus_fabric_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_TARGETS(3)) bus ();
   pe_bus_fabric dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int n_vec = 0;
   int n_err = 0;

   // Model state: pending response, character queue, error registers
   int          m_kind;   // 0 none, 1 target, 2 putchar, 3 illegal
   int          m_idx;
   logic [7:0]  q[$];
   logic        m_irq;
   logic [31:0] m_addr;
   int          m_cnt;

   // Inputs applied at the next drive point
   logic [2:0]  nx_ready  = 3'b111;
   logic        nx_pready = 1'b0;
   logic        nx_clr    = 1'b0;
   logic [95:0] nx_rdata  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   task automatic decode(input logic req, input logic [31:0] a, output int kind, output int idx);
      kind = 0;
      idx  = 0;
      if (req) begin
         if (a == PUTC) kind = 2;
         else begin
            kind = 3;
            for (int k = 0; k < 3; k++) begin
               if (kind == 3 && (a & ~MASK[k]) == BASE[k]) begin
                  kind = 1;
                  idx  = k;
               end
            end
         end
      end
   endtask

   function automatic logic exp_stall(input int kind, input int idx);
      logic pop;
      pop = (q.size() > 0) && bus.putc_ready;
      return (kind == 1 && !bus.tgt_ready[idx]) ||
             (kind == 2 && bus.cpu_wb != 4'h0 && q.size() == DEPTH && !pop);
   endfunction

   task automatic model_reset();
      m_kind = 0; m_idx = 0; q.delete();
      m_irq = 1'b0; m_addr = '0; m_cnt = 0;
   endtask

   task automatic check_all();
      int kind, idx;
      logic [31:0] rd;
      decode(bus.cpu_req, bus.cpu_addr, kind, idx);
      check("stall", 32'(bus.cpu_stall_c), 32'(exp_stall(kind, idx)));
      check("tgt_sel", 32'(bus.tgt_sel_c), (kind == 1) ? (32'd1 << idx) : 32'd0);
      check("tgt_addr", bus.tgt_addr_c, (kind == 1) ? (bus.cpu_addr & MASK[idx]) : 32'd0);
      check("tgt_wb", 32'(bus.tgt_wb_c), (kind == 1) ? 32'(bus.cpu_wb) : 32'd0);
      check("tgt_wdata", bus.tgt_wdata_c, bswap(bus.cpu_wdata));
      case (m_kind)
         1:       rd = bswap(bus.tgt_rdata[m_idx*32 +: 32]);
         2, 3:    rd = ERRD;
         default: rd = 32'd0;
      endcase
      check("cpu_rdata", bus.cpu_rdata_c, rd);
      check("putc_valid", 32'(bus.putc_valid), 32'(q.size() != 0));
      check("putc_data", 32'(bus.putc_data_c), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      check("err_irq", 32'(bus.err_irq), 32'(m_irq));
      check("err_addr", bus.err_addr, m_addr);
      check("err_count", 32'(bus.err_count), 32'(m_cnt));
   endtask

   task automatic drive_check(input logic req, input logic [31:0] a, input logic [3:0] wb,
                              input logic [31:0] wd);
      @(negedge clk);
      bus.cpu_req    = req;
      bus.cpu_addr   = a;
      bus.cpu_wb     = wb;
      bus.cpu_wdata  = wd;
      bus.tgt_ready  = nx_ready;
      bus.putc_ready = nx_pready;
      bus.err_clr    = nx_clr;
      bus.tgt_rdata  = nx_rdata;
      #1;
      check_all();
   endtask

   // Advance one clock and apply the transaction-level effects of the sampled inputs
   task automatic tick();
      int kind, idx;
      logic stall, pop, acc;
      @(posedge clk);
      decode(bus.cpu_req, bus.cpu_addr, kind, idx);
      stall = exp_stall(kind, idx);
      pop   = (q.size() > 0) && bus.putc_ready;
      acc   = bus.cpu_req && !stall;
      if (pop) void'(q.pop_front());
      if (acc && kind == 2 && bus.cpu_wb != 4'h0) q.push_back(bus.cpu_wdata[7:0]);
      m_kind = acc ? kind : 0;
      m_idx  = idx;
      if (acc && kind == 3) begin
         if (!m_irq || bus.err_clr) m_addr = bus.cpu_addr;
         m_cnt = bus.err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         m_irq = 1'b1;
      end else if (bus.err_clr) begin
         m_irq = 1'b0; m_addr = '0; m_cnt = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.cpu_req = 1'b0; bus.cpu_wb = '0; bus.err_clr = 1'b0; bus.putc_ready = 1'b0;
      nx_clr = 1'b0; nx_pready = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      check("rst_pvalid", 32'(bus.putc_valid), 32'd0);
      check("rst_rdata", bus.cpu_rdata_c, 32'd0);
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic idle();
      drive_check(1'b0, 32'd0, 4'h0, $urandom);
      tick();
   endtask

   initial begin
      int k, pops, budget;
      logic [31:0] a;
      bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wb = '0; bus.cpu_wdata = '0;
      bus.tgt_rdata = '0; bus.tgt_ready = '1; bus.putc_ready = 1'b0; bus.err_clr = 1'b0;
      model_reset();
      do_reset();

      // RAM read with byte swap on return
      nx_ready = 3'b111;
      nx_rdata = {32'h0, 32'h1122_3344, 32'h0};
      drive_check(1'b1, 32'h4000_0010, 4'h0, 32'h0);
      check("ram_taddr", bus.tgt_addr_c, 32'h10);
      tick();
      drive_check(1'b0, 32'h0, 4'h0, 32'h0);
      check("ram_rdata", bus.cpu_rdata_c, 32'h4433_2211);
      tick();

      // Boot read held off by target for three cycles
      nx_ready = 3'b110;
      nx_rdata = {64'h0, 32'hAABB_CCDD};
      for (int i = 0; i < 3; i++) begin
         drive_check(1'b1, 32'h4, 4'h0, 32'h0);
         check("boot_stall", 32'(bus.cpu_stall_c), 32'd1);
         tick();
      end
      nx_ready = 3'b111;
      drive_check(1'b1, 32'h4, 4'h0, 32'h0);
      check("boot_go", 32'(bus.cpu_stall_c), 32'd0);
      tick();
      drive_check(1'b0, 32'h0, 4'h0, 32'h0);
      check("boot_rdata", bus.cpu_rdata_c, 32'hDDCC_BBAA);
      tick();

      // Putchar FIFO fills at eight, ninth write waits for the host
      nx_pready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drive_check(1'b1, PUTC, 4'hF, 32'h41);
         check("putc_stall", 32'(bus.cpu_stall_c), (i == 8) ? 32'd1 : 32'd0);
         tick();
      end
      nx_pready = 1'b1;
      pops = 0;
      drive_check(1'b1, PUTC, 4'hF, 32'h41);
      check("putc_full_pop", 32'(bus.cpu_stall_c), 32'd0);
      if (bus.putc_valid && bus.putc_data_c == 8'h41) pops++;
      tick();
      budget = 0;
      while (bus.putc_valid && budget < 20) begin
         drive_check(1'b0, 32'h0, 4'h0, 32'h0);
         if (bus.putc_valid && bus.putc_data_c == 8'h41) pops++;
         tick();
         budget++;
      end
      check("putc_drained", 32'(bus.putc_valid), 32'd0);
      check("putc_pops", 32'(pops), 32'd9);
      nx_pready = 1'b0;

      // Illegal reads: no stall, error data, first address kept
      drive_check(1'b1, 32'h8000_0000, 4'h0, 32'h0);
      check("ill1_stall", 32'(bus.cpu_stall_c), 32'd0);
      tick();
      drive_check(1'b1, 32'h9000_0000, 4'h0, 32'h0);
      check("ill1_rdata", bus.cpu_rdata_c, ERRD);
      tick();
      drive_check(1'b0, 32'h0, 4'h0, 32'h0);
      check("ill2_rdata", bus.cpu_rdata_c, ERRD);
      check("ill_irq", 32'(bus.err_irq), 32'd1);
      check("ill_addr", bus.err_addr, 32'h8000_0000);
      check("ill_cnt", 32'(bus.err_count), 32'd2);
      tick();

      // Clear concurrent with a new illegal access, then saturation
      nx_clr = 1'b1;
      drive_check(1'b1, 32'hA000_0000, 4'h0, 32'h0);
      tick();
      nx_clr = 1'b0;
      drive_check(1'b0, 32'h0, 4'h0, 32'h0);
      check("clr_addr", bus.err_addr, 32'hA000_0000);
      check("clr_cnt", 32'(bus.err_count), 32'd1);
      tick();
      for (int i = 0; i < 300; i++) begin
         drive_check(1'b1, 32'hA000_0000 + 32'(i), 4'h0, 32'h0);
         tick();
      end
      drive_check(1'b0, 32'h0, 4'h0, 32'h0);
      check("sat_cnt", 32'(bus.err_count), 32'd255);
      tick();

      // Reset with three queued chars and a read pending
      for (int i = 0; i < 3; i++) begin
         drive_check(1'b1, PUTC, 4'h1, 32'h61 + 32'(i));
         tick();
      end
      drive_check(1'b1, 32'h4000_0020, 4'h0, 32'h0);
      tick();
      do_reset();
      idle();

      // Randomized traffic across all regions, boundaries and the putchar port
      for (int i = 0; i < 2000; i++) begin
         k = $urandom_range(0, 2);
         case ($urandom_range(0, 6))
            0, 1, 2: a = BASE[k] | ($urandom & MASK[k]);
            3:       a = BASE[k] + MASK[k] + 32'd1;
            4:       a = PUTC;
            5:       a = $urandom;
            default: a = BASE[k] + MASK[k];
         endcase
         nx_ready  = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
         nx_pready = ($urandom_range(0, 2) == 0);
         nx_clr    = ($urandom_range(0, 15) == 0);
         nx_rdata  = {$urandom, $urandom, $urandom};
         drive_check(($urandom_range(0, 3) != 0), a,
                     ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), $urandom);
         tick();
      end
      nx_clr = 1'b0;
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1, "timeout");
   end
endmodule
